// File: rtl/imem_responder_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory responder:
//   - FSM state encodings (IMEM_IDLE .. IMEM_HOLD)
//   - RV_NOP, the instruction returned for a misaligned fetch
//   - IMEM_CTR_W, width of the wait-state counter
//   - is_misaligned(), low-address-bit test used by the optional
//     IMEM_MISALIGN_EN feature
// ----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_CTR_W = 3;

    localparam logic [2:0] IMEM_IDLE = 3'd0;
    localparam logic [2:0] IMEM_WAIT = 3'd1;
    localparam logic [2:0] IMEM_READ = 3'd2;
    localparam logic [2:0] IMEM_CAP  = 3'd3;
    localparam logic [2:0] IMEM_HOLD = 3'd4;

    localparam logic [31:0] RV_NOP = 32'h00000013;

    function automatic logic is_misaligned(input logic [1:0] byte_lo);
        return byte_lo != 2'b00;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// ----------------------------------------------------------------------------
// imem_responder_if
// Fetch handshake between the pipeline front end and the instruction-memory
// responder.
//   reqValid / reqAddr : fetch request (byte address)
//   stall              : consumer cannot take rdata this cycle
//   flush              : redirect, kills any in-flight or held response
//   memReady           : responder idle or holding valid data
//   rvalid / rdata     : fetched instruction
// Modports: master = pipeline side, slave = responder side.
// ----------------------------------------------------------------------------
interface imem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              reqValid;
    logic [ADDR_W-1:0] reqAddr;
    logic              stall;
    logic              flush;
    logic              memReady;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output reqValid,
        output reqAddr,
        output stall,
        output flush,
        input  memReady,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  reqValid,
        input  reqAddr,
        input  stall,
        input  flush,
        output memReady,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/imem_responder_wait_ctr.sv
// ----------------------------------------------------------------------------
// imem_wait_ctr
// Loadable down-counter that times the wait states before a ROM read.
//   clk      : rising-edge clock
//   reset    : synchronous, active-high; clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value loaded on load
//   dec      : decrement by one; saturates at zero instead of wrapping
//   done     : count is 1, i.e. this is the last wait cycle
// ----------------------------------------------------------------------------
module imem_wait_ctr
    import imem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [IMEM_CTR_W-1:0] load_val,
    input  logic                  dec,
    output logic                  done
);

    logic [IMEM_CTR_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == IMEM_CTR_W'(1));

endmodule

// File: rtl/imem_responder.sv
// ----------------------------------------------------------------------------
// imem_responder
// Instruction-memory side of the fetch handshake. Accepts a fetch request,
// waits WAIT_CYCLES cycles, reads a synchronous ROM port, captures the word
// and holds it (rvalid) until the pipeline consumes it. flush abandons any
// in-flight or held response; a request arriving with flush is accepted as a
// jump target.
//
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous, active-high
//   fetch    : imem_responder_if.slave (reqValid, reqAddr, stall, flush,
//              memReady, rvalid, rdata)
//   memEn    : ROM read enable (high in READ only)
//   memAddr  : ROM word address latched at accept
//   memRdata : ROM data, valid the cycle after memEn
//   misalign : (only with IMEM_MISALIGN_EN) held response is the NOP
//              returned for a misaligned address
//
// Optional feature macro: IMEM_MISALIGN_EN. When defined, an accepted request
// with reqAddr[1:0] != 0 skips the ROM and goes straight to HOLD with RV_NOP.
// ----------------------------------------------------------------------------
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_responder_if.slave       fetch,
    output logic                  memEn,
    output logic [DEPTH_LOG2-1:0] memAddr,
    input  logic [DATA_W-1:0]     memRdata
`ifdef IMEM_MISALIGN_EN
    ,
    output logic                  misalign
`endif
);

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [DATA_W-1:0]     rdata_reg;
    logic [DEPTH_LOG2-1:0] addr_reg;
    logic                  accept;
    logic                  capture;
    logic                  req_misaligned;
    logic [2:0]            accept_state;
    logic                  ctr_done;

    // Upper address bits beyond the ROM and the byte offset are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch.reqAddr[ADDR_W-1:DEPTH_LOG2+2], fetch.reqAddr[1:0]};

`ifdef IMEM_MISALIGN_EN
    assign req_misaligned = is_misaligned(fetch.reqAddr[1:0]);
`else
    assign req_misaligned = 1'b0;
`endif

    // Where a freshly accepted request goes: misaligned requests bypass the
    // ROM entirely, zero wait states go straight to the read.
    assign accept_state = req_misaligned      ? IMEM_HOLD :
                          (WAIT_CYCLES == 0)  ? IMEM_READ : IMEM_WAIT;

    always_comb begin
        state_next = state_reg;

        // A request is taken when idle, when the held word is being consumed
        // (back-to-back), or alongside a flush (jump target) in any state.
        accept = fetch.reqValid &&
                 (fetch.flush ||
                  (state_reg == IMEM_IDLE) ||
                  ((state_reg == IMEM_HOLD) && !fetch.stall));

        case (state_reg)
            IMEM_IDLE: ;
            IMEM_WAIT: begin
                if (fetch.flush) begin
                    state_next = IMEM_IDLE;
                end else if (ctr_done) begin
                    state_next = IMEM_READ;
                end
            end
            IMEM_READ: state_next = fetch.flush ? IMEM_IDLE : IMEM_CAP;
            IMEM_CAP:  state_next = fetch.flush ? IMEM_IDLE : IMEM_HOLD;
            IMEM_HOLD: begin
                // flush wins over stall: the held word is dropped.
                if (fetch.flush || !fetch.stall) begin
                    state_next = IMEM_IDLE;
                end
            end
            default:   state_next = IMEM_IDLE;
        endcase

        if (accept) begin
            state_next = accept_state;
        end
    end

    // A flushed capture must leave rdata untouched.
    assign capture = (state_reg == IMEM_CAP) && !fetch.flush;

    imem_wait_ctr u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (IMEM_CTR_W'(WAIT_CYCLES)),
        .dec      (state_reg == IMEM_WAIT),
        .done     (ctr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IMEM_IDLE;
            rdata_reg <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg <= fetch.reqAddr[DEPTH_LOG2+1:2];
            end
            if (accept && req_misaligned) begin
                rdata_reg <= DATA_W'(RV_NOP);
            end else if (capture) begin
                rdata_reg <= memRdata;
            end
        end
    end

`ifdef IMEM_MISALIGN_EN
    logic misalign_reg;

    // Set by a misaligned accept, cleared as soon as HOLD is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_reg <= 1'b0;
        end else if (accept) begin
            misalign_reg <= req_misaligned;
        end else if (state_next != IMEM_HOLD) begin
            misalign_reg <= 1'b0;
        end
    end

    assign misalign = misalign_reg;
`endif

    assign fetch.memReady = (state_reg == IMEM_IDLE) || (state_reg == IMEM_HOLD);
    assign fetch.rvalid   = (state_reg == IMEM_HOLD);
    assign fetch.rdata    = rdata_reg;
    assign memEn          = (state_reg == IMEM_READ);
    assign memAddr        = addr_reg;

endmodule

// File: tb/tb_imem_responder.sv
// ----------------------------------------------------------------------------
// tb_imem_responder
// Drives imem_responder with directed fetch scenarios followed by random
// request/stall/flush/reset traffic. A timeline model (request accepted at
// cycle T -> ROM read at T+W+1 -> held response from T+W+3) predicts every
// output each cycle; directed literal checks pin the model to known values.
// ----------------------------------------------------------------------------
module tb_imem_responder;

    localparam int A = 32;
    localparam int D = 32;
    localparam int DL = 10;
    localparam int W = 3;

    logic clk;
    logic reset;
    logic memEn;
    logic [DL-1:0] memAddr;
    logic [D-1:0] memRdata;
`ifdef IMEM_MISALIGN_EN
    logic misalign;
`endif

    imem_responder_if #(.ADDR_W(A), .DATA_W(D)) fetch_if ();

    imem_responder #(
        .ADDR_W(A), .DATA_W(D), .DEPTH_LOG2(DL), .WAIT_CYCLES(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fetch    (fetch_if),
        .memEn    (memEn),
        .memAddr  (memAddr),
        .memRdata (memRdata)
`ifdef IMEM_MISALIGN_EN
        ,
        .misalign (misalign)
`endif
    );

    logic [D-1:0] rom [0:(1<<DL)-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM; returns noise when not enabled so a mistimed capture shows.
    always @(posedge clk) begin
        if (memEn) memRdata <= rom[memAddr];
        else       memRdata <= $urandom;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic          m_inflight, m_hold, m_mis;
    logic [D-1:0]  m_rdata;
    logic [DL-1:0] m_addr;
    int            m_acc, cyc;

    initial begin
        int age;
        logic acc, req_mis;
        m_inflight = 0; m_hold = 0; m_mis = 0; m_rdata = '0; m_addr = '0;
        m_acc = 0; cyc = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            age = cyc - m_acc;
            chk("memReady", 64'(fetch_if.memReady), 64'(!m_inflight));
            chk("rvalid",   64'(fetch_if.rvalid),   64'(m_hold));
            chk("rdata",    64'(fetch_if.rdata),    64'(m_rdata));
            chk("memEn",    64'(memEn),             64'(m_inflight && (age == W + 1)));
            chk("memAddr",  64'(memAddr),           64'(m_addr));
`ifdef IMEM_MISALIGN_EN
            chk("misalign", 64'(misalign),          64'(m_hold && m_mis));
            req_mis = (fetch_if.reqAddr[1:0] != 2'b00);
`else
            req_mis = 1'b0;
`endif
            if (reset) begin
                m_inflight = 0; m_hold = 0; m_mis = 0; m_rdata = '0; m_addr = '0;
            end else begin
                acc = fetch_if.reqValid &&
                      (fetch_if.flush || (!m_inflight && !m_hold) || (m_hold && !fetch_if.stall));
                if (fetch_if.flush) begin
                    m_inflight = 0;
                    m_hold = 0;
                end else begin
                    if (m_hold && !fetch_if.stall) m_hold = 0;
                    if (m_inflight && (age == W + 2)) begin
                        m_inflight = 0;
                        m_hold = 1;
                        m_mis = 0;
                        m_rdata = rom[m_addr];
                    end
                end
                if (acc) begin
                    m_addr = fetch_if.reqAddr[DL+1:2];
                    if (req_mis) begin
                        m_hold = 1; m_mis = 1; m_inflight = 0;
                        m_rdata = 32'h00000013;
                    end else begin
                        m_hold = 0; m_inflight = 1; m_acc = cyc;
                    end
                end
                if (!m_hold) m_mis = 0;
            end
            cyc++;
        end
    end

    // Steps until rvalid (bounded); drops reqValid/flush after the first edge.
    task automatic run_until_rvalid(output int k, output logic first_rv);
        k = 0;
        first_rv = 1'b0;
        do begin
            step();
            k++;
            if (k == 1) begin
                fetch_if.reqValid = 1'b0;
                fetch_if.flush = 1'b0;
                first_rv = fetch_if.rvalid;
            end
        end while (!fetch_if.rvalid && k < 40);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        logic first_rv;
        logic seen;
        logic [D-1:0] saved;

        for (int i = 0; i < (1 << DL); i++) rom[i] = $urandom;
        rom[5] = 32'hDEADBEEF;
        rom[6] = 32'h00A00093;

        reset = 1'b1;
        fetch_if.reqValid = 1'b0;
        fetch_if.reqAddr = '0;
        fetch_if.stall = 1'b0;
        fetch_if.flush = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        chk("rst_memReady", 64'(fetch_if.memReady), 64'd1);
        chk("rst_rvalid",   64'(fetch_if.rvalid),   64'd0);
        chk("rst_rdata",    64'(fetch_if.rdata),    64'd0);
        chk("rst_memEn",    64'(memEn),             64'd0);
        chk("rst_memAddr",  64'(memAddr),           64'd0);

        // Single fetch from 0x14
        fetch_if.reqValid = 1'b1; fetch_if.reqAddr = 32'h14;
        step();
        fetch_if.reqValid = 1'b0;
        chk("t1_busy_T1", 64'(fetch_if.memReady), 64'd0);
        repeat (3) step();
        chk("t1_memEn_T4",   64'(memEn),   64'd1);
        chk("t1_memAddr_T4", 64'(memAddr), 64'd5);
        step();
        chk("t1_busy_T5", 64'(fetch_if.memReady), 64'd0);
        step();
        chk("t1_rvalid_T6", 64'(fetch_if.rvalid), 64'd1);
        chk("t1_rdata_T6",  64'(fetch_if.rdata),  64'h00000000DEADBEEF);

        // Stall hold for 4 cycles
        fetch_if.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_hold_rvalid", 64'(fetch_if.rvalid), 64'd1);
            chk("t2_hold_rdata",  64'(fetch_if.rdata),  64'h00000000DEADBEEF);
        end
        fetch_if.stall = 1'b0;
        step();
        chk("t2_idle_rvalid",   64'(fetch_if.rvalid),   64'd0);
        chk("t2_idle_memReady", 64'(fetch_if.memReady), 64'd1);

        // Back-to-back
        fetch_if.reqValid = 1'b1; fetch_if.reqAddr = 32'h14;
        run_until_rvalid(k, first_rv);
        chk("t3_first_latency", 64'(k), 64'd6);
        fetch_if.reqValid = 1'b1; fetch_if.reqAddr = 32'h18;
        run_until_rvalid(k, first_rv);
        chk("t3_b2b_latency", 64'(k), 64'd6);
        chk("t3_b2b_rdata",   64'(fetch_if.rdata), 64'h0000000000A00093);
        step();

        // Flush in WAIT
        saved = fetch_if.rdata;
        fetch_if.reqValid = 1'b1; fetch_if.reqAddr = 32'h14;
        step();
        fetch_if.reqValid = 1'b0;
        step();
        fetch_if.flush = 1'b1;
        step();
        fetch_if.flush = 1'b0;
        chk("t4_idle_memReady", 64'(fetch_if.memReady), 64'd1);
        chk("t4_rdata_kept",    64'(fetch_if.rdata),    64'(saved));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (memEn || fetch_if.rvalid) seen = 1'b1;
            step();
        end
        chk("t4_no_memEn_rvalid", 64'(seen), 64'd0);

        // Flush plus redirect in HOLD
        fetch_if.reqValid = 1'b1; fetch_if.reqAddr = 32'h14;
        run_until_rvalid(k, first_rv);
        chk("t5_pre_rdata", 64'(fetch_if.rdata), 64'h00000000DEADBEEF);
        fetch_if.stall = 1'b1;
        fetch_if.flush = 1'b1; fetch_if.reqValid = 1'b1; fetch_if.reqAddr = 32'h18;
        run_until_rvalid(k, first_rv);
        fetch_if.stall = 1'b0;
        chk("t5_rvalid_drop",   64'(first_rv),       64'd0);
        chk("t5_redir_latency", 64'(k),              64'd6);
        chk("t5_redir_rdata",   64'(fetch_if.rdata), 64'h0000000000A00093);
        step();

        // Reset mid-READ
        fetch_if.reqValid = 1'b1; fetch_if.reqAddr = 32'h18;
        step();
        fetch_if.reqValid = 1'b0;
        repeat (3) step();
        chk("t6_in_read", 64'(memEn), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_memReady", 64'(fetch_if.memReady), 64'd1);
        chk("t6_rvalid",   64'(fetch_if.rvalid),   64'd0);
        chk("t6_rdata",    64'(fetch_if.rdata),    64'd0);
        chk("t6_memEn",    64'(memEn),             64'd0);
        chk("t6_memAddr",  64'(memAddr),           64'd0);
        repeat (6) step();

`ifdef IMEM_MISALIGN_EN
        // Misaligned fetch returns NOP without touching the ROM
        fetch_if.reqValid = 1'b1; fetch_if.reqAddr = 32'h16;
        step();
        fetch_if.reqValid = 1'b0;
        chk("t7_rvalid",   64'(fetch_if.rvalid), 64'd1);
        chk("t7_rdata",    64'(fetch_if.rdata),  64'h0000000000000013);
        chk("t7_misalign", 64'(misalign),        64'd1);
        chk("t7_memEn",    64'(memEn),           64'd0);
        step();
        chk("t7_misalign_clr", 64'(misalign), 64'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            fetch_if.reqValid = ($urandom_range(0, 9) < 4);
            fetch_if.reqAddr  = {$urandom_range(0, 255), 2'b00};
            fetch_if.reqAddr[A-1:DL+2] = 20'($urandom);
            if ($urandom_range(0, 4) == 0) fetch_if.reqAddr[1:0] = 2'($urandom_range(1, 3));
            fetch_if.stall = ($urandom_range(0, 9) < 3);
            fetch_if.flush = ($urandom_range(0, 19) == 0);
            reset          = ($urandom_range(0, 99) == 0);
            step();
        end
        fetch_if.reqValid = 1'b0;
        fetch_if.stall = 1'b0;
        fetch_if.flush = 1'b0;
        reset = 1'b0;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
